// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter taking bytes over a valid/ready handshake.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy
);
    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state_q;
    logic              tx_q;
    logic [2:0]        bit_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] shift_q;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif

    // Cycle counter wraps at every bit boundary, so one counter times all states.
    assign bit_end = (cnt_q == CNT_LAST);
    assign cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            tx_q     <= 1'b1;
            bit_q    <= '0;
            cnt_q    <= '0;
            shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shift_q  <= tx_data;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^tx_data;
`endif
                        state_q  <= START;
                        tx_q     <= 1'b0;
                        cnt_q    <= '0;
                        bit_q    <= '0;
                    end
                end
                START: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            // Bit 1 becomes bit 0 after this edge's shift.
                            tx_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    cnt_q <= cnt_d;
                    if (bit_end) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = ~tx_ready;
    assign tx       = tx_q;

endmodule
